// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
//   Shared constants and types for the architectural register file and its
//   read ports: register-id width, ROB-id width and range, the reserved
//   "no producer" ROB id, and the register count.
// -----------------------------------------------------------------------------
package reg_file_pkg;

  localparam int RF_NUM_REGS     = 32;
  localparam int REG_ID_WIDTH    = 5;
  localparam int DATA_WIDTH      = 32;
  localparam int RF_ROB_ID_WIDTH = 5;

  // Number of encodable ROB ids; id 0 is reserved, so 1..ROB_RANGE-1 are usable.
  localparam int ROB_RANGE = 1 << RF_ROB_ID_WIDTH;

  typedef logic [REG_ID_WIDTH-1:0]    reg_id_t;
  typedef logic [DATA_WIDTH-1:0]      data_t;
  typedef logic [RF_ROB_ID_WIDTH-1:0] rob_id_t;

  // A tag equal to this value means the register holds its committed value.
  localparam rob_id_t ROB_ID_INVALID = '0;

  // Architectural register x0 is hardwired to zero.
  localparam reg_id_t REG_ZERO = '0;

endpackage : reg_file_pkg

// File: rtl/reg_read_port.sv
// -----------------------------------------------------------------------------
// reg_read_port
//   Combinational operand read for one source register. Takes the stored
//   value/tag already selected by rs_id and applies:
//     - x0 masking (always value 0, rob id 0)
//     - commit bypass: a same-cycle commit whose ROB id matches the pending
//       tag makes the operand ready with the committing data.
//
// Ports:
//   rs_id          source register id
//   stored_value   value[rs_id] (pre-edge state)
//   stored_tag     tag[rs_id]   (pre-edge state)
//   commit_*       the ROB commit write of this cycle
//   rs_value       operand value, meaningful when rs_rob_id == 0
//   rs_rob_id      pending producer ROB id, 0 when ready
// -----------------------------------------------------------------------------
module reg_read_port
  import reg_file_pkg::*;
#(
  parameter int ROB_ID_WIDTH = RF_ROB_ID_WIDTH
) (
  input  logic [REG_ID_WIDTH-1:0] rs_id,
  input  logic [DATA_WIDTH-1:0]   stored_value,
  input  logic [ROB_ID_WIDTH-1:0] stored_tag,
  input  logic                    commit_enabled,
  input  logic [REG_ID_WIDTH-1:0] commit_reg_id,
  input  logic [DATA_WIDTH-1:0]   commit_data,
  input  logic [ROB_ID_WIDTH-1:0] commit_rob_id,
  output logic [DATA_WIDTH-1:0]   rs_value,
  output logic [ROB_ID_WIDTH-1:0] rs_rob_id
);

  logic bypass_hit;

  // The tag match matters: if a younger rename already replaced the tag,
  // the commit belongs to an older producer and the operand stays pending.
  assign bypass_hit = commit_enabled
                   && (rs_id != REG_ZERO)
                   && (commit_reg_id == rs_id)
                   && (stored_tag == commit_rob_id);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned; that is what keeps latches from being inferred.
  always_comb begin
    rs_value  = stored_value;
    rs_rob_id = stored_tag;
    if (rs_id == REG_ZERO) begin
      rs_value  = '0;
      rs_rob_id = '0;
    end else if (bypass_hit) begin
      rs_value  = commit_data;
      rs_rob_id = '0;
    end
  end

endmodule : reg_read_port

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
//   Architectural register file with per-register ROB-tag (rename) tracking.
//   Written by ROB commits (value + conditional tag clear) and by decoder
//   renames (tag set); read combinationally by the decoder through two
//   reg_read_port instances that resolve each source as a ready value or a
//   pending ROB id.
//
// Ports:
//   clk_in           system clock
//   rst_in           asynchronous active-low reset; clears all values and tags
//   flush_in         pipeline flush: clears all tags, suppresses renames
//   commit_enabled   commit write valid
//   commit_reg_id    commit destination register
//   commit_data      committed value
//   commit_rob_id    ROB id of the committing entry
//   rename_enabled   rename valid
//   rename_reg_id    destination register being renamed
//   rename_rob_id    ROB id allocated to the renamed instruction
//   rs1_id/rs2_id    source registers to read
//   rs1_value/rs2_value    operand values (valid when rob id is 0)
//   rs1_rob_id/rs2_rob_id  pending producer ROB ids, 0 when ready
// -----------------------------------------------------------------------------
module reg_file
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS     = RF_NUM_REGS,
  parameter int ROB_ID_WIDTH = RF_ROB_ID_WIDTH
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    flush_in,
  input  logic                    commit_enabled,
  input  logic [REG_ID_WIDTH-1:0] commit_reg_id,
  input  logic [DATA_WIDTH-1:0]   commit_data,
  input  logic [ROB_ID_WIDTH-1:0] commit_rob_id,
  input  logic                    rename_enabled,
  input  logic [REG_ID_WIDTH-1:0] rename_reg_id,
  input  logic [ROB_ID_WIDTH-1:0] rename_rob_id,
  input  logic [REG_ID_WIDTH-1:0] rs1_id,
  input  logic [REG_ID_WIDTH-1:0] rs2_id,
  output logic [DATA_WIDTH-1:0]   rs1_value,
  output logic [ROB_ID_WIDTH-1:0] rs1_rob_id,
  output logic [DATA_WIDTH-1:0]   rs2_value,
  output logic [ROB_ID_WIDTH-1:0] rs2_rob_id
);

  logic [DATA_WIDTH-1:0]   value_q [NUM_REGS];
  logic [ROB_ID_WIDTH-1:0] tag_q   [NUM_REGS];
  logic [DATA_WIDTH-1:0]   value_d [NUM_REGS];
  logic [ROB_ID_WIDTH-1:0] tag_d   [NUM_REGS];

  // ---------------------------------------------------------------------------
  // Next-state: entry 0 is never written, so it keeps its reset value of 0.
  // Tag priority per register: flush > rename > matching commit clear.
  // ---------------------------------------------------------------------------
  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      // A commit always writes its value, even under flush or a same-cycle
      // rename of the same register.
      if (commit_enabled && (commit_reg_id == REG_ID_WIDTH'(i))) begin
        value_d[i] = commit_data;
      end

      if (flush_in) begin
        tag_d[i] = '0;
      end else if (rename_enabled && (rename_reg_id == REG_ID_WIDTH'(i))) begin
        tag_d[i] = rename_rob_id;
      end else if (commit_enabled && (commit_reg_id == REG_ID_WIDTH'(i))
                   && (tag_q[i] == commit_rob_id)) begin
        // Only the producer the tag still names may mark the register ready;
        // an older commit after a younger rename leaves the tag alone.
        tag_d[i] = '0;
      end
    end
  end

  // NOTE: the register array is built from flops rather than a RAM macro, so
  // it can be reset as a whole; an asynchronous reset drops every pending tag
  // at once, without waiting for a clock edge.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      value_q <= value_d;
      tag_q   <= tag_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: see pre-edge state, so a same-cycle rename is invisible.
  // ---------------------------------------------------------------------------
  reg_read_port #(
    .ROB_ID_WIDTH (ROB_ID_WIDTH)
  ) u_rs1_port (
    .rs_id          (rs1_id),
    .stored_value   (value_q[rs1_id]),
    .stored_tag     (tag_q[rs1_id]),
    .commit_enabled (commit_enabled),
    .commit_reg_id  (commit_reg_id),
    .commit_data    (commit_data),
    .commit_rob_id  (commit_rob_id),
    .rs_value       (rs1_value),
    .rs_rob_id      (rs1_rob_id)
  );

  reg_read_port #(
    .ROB_ID_WIDTH (ROB_ID_WIDTH)
  ) u_rs2_port (
    .rs_id          (rs2_id),
    .stored_value   (value_q[rs2_id]),
    .stored_tag     (tag_q[rs2_id]),
    .commit_enabled (commit_enabled),
    .commit_reg_id  (commit_reg_id),
    .commit_data    (commit_data),
    .commit_rob_id  (commit_rob_id),
    .rs_value       (rs2_value),
    .rs_rob_id      (rs2_rob_id)
  );

endmodule : reg_file
